// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//   Shared constants for the 5-stage RV32 core pipeline blocks.
//   REG_ADDR_W : width of an architectural register index.
//   REG_X0     : index of the hard-wired zero register, which never carries a
//                real data dependency.
// ----------------------------------------------------------------------------
package core_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage : core_pkg

// File: rtl/hazard_sat_counter.sv
// ----------------------------------------------------------------------------
// hazard_sat_counter
//   Saturating event counter used for the hazard unit statistics.
//   It counts one per clock edge while inc is high and holds at all-ones
//   instead of wrapping.
//
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset; clears count on the edge
//   inc    in   count this cycle
//   count  out  current count value (CNT_W bits)
// ----------------------------------------------------------------------------
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Once every bit is set the value is pinned there; further events are lost
  // rather than wrapping back to a misleadingly small number.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : hazard_sat_counter

// File: rtl/hazard_detection.sv
// ----------------------------------------------------------------------------
// hazard_detection
//   Hazard unit sitting beside the ID/EX boundary of the 5-stage RV32 core.
//   - Load-use hazard: the instruction in EX is a load whose destination is
//     read by the instruction in ID. PC and IF/ID are frozen for one cycle.
//   - Control redirect: a taken branch/jump resolved this cycle; the
//     instruction entering EX is turned into a bubble.
//   The load-use stall wins over a redirect: while frozen, nothing new is
//   being fetched, and the redirect will be re-presented next cycle.
//   Hazard outputs are purely combinational and do not depend on clk/rst_n.
//   Two saturating counters record stall cycles and flush cycles.
//
// Ports:
//   clk                 in   clock for the statistics counters only
//   rst_n               in   synchronous active-low reset (counters only)
//   id_rs1, id_rs2      in   source registers of the instruction in ID
//   ex_rd               in   destination register of the instruction in EX
//   ex_memread          in   instruction in EX is a load
//   pc_redirect         in   taken branch or jump resolved this cycle
//   pc_write_enable     out  1 = PC may update
//   if_id_write_enable  out  1 = IF/ID register may update
//   flush_ex            out  1 = bubble the instruction entering EX
//   stall_count         out  cycles with a load-use stall (saturating)
//   flush_count         out  cycles with a flush (saturating)
// ----------------------------------------------------------------------------
module hazard_detection #(
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  pc_redirect,
  output logic                  pc_write_enable,
  output logic                  if_id_write_enable,
  output logic                  flush_ex,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  import core_pkg::*;

  logic rd_is_x0;
  logic rs_match;
  logic load_use;

  // x0 is hard-wired to zero, so a load "to x0" produces nothing a later
  // instruction can depend on, even if that instruction also names x0.
  assign rd_is_x0 = (ex_rd == REG_ADDR_W'(REG_X0));
  assign rs_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
  assign load_use = ex_memread && !rd_is_x0 && rs_match;

  always_comb begin
    pc_write_enable    = 1'b1;
    if_id_write_enable = 1'b1;
    flush_ex           = 1'b0;
    if (load_use) begin
      pc_write_enable    = 1'b0;
      if_id_write_enable = 1'b0;
    end else if (pc_redirect) begin
      flush_ex = 1'b1;
    end
  end

  // flush_ex is already masked by load_use, so a flush is never counted in a
  // stall cycle.
  hazard_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (load_use),
    .count (stall_count)
  );

  hazard_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_ex),
    .count (flush_count)
  );

endmodule : hazard_detection

// File: tb/tb_hazard_detection.sv
// ----------------------------------------------------------------------------
// tb_hazard_detection
//   Three instances share the same hazard inputs:
//     u_dut : CNT_W = 32, normal clock and reset
//     u_sat : CNT_W = 2, same clock and reset, exercises saturation
//     u_nc  : clock and reset held at X, combinational outputs only
// ----------------------------------------------------------------------------
module tb_hazard_detection;

  localparam int RW = 5;

  logic          clk;
  logic          rst_n;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic [RW-1:0] ex_rd;
  logic          ex_memread;
  logic          pc_redirect;

  logic          pcw, ifidw, flush;
  logic [31:0]   stall_cnt, flush_cnt;
  logic          pcw_s, ifidw_s, flush_s;
  logic [1:0]    stall_cnt_s, flush_cnt_s;
  logic          pcw_n, ifidw_n, flush_n;
  logic [31:0]   stall_cnt_n, flush_cnt_n;
  logic          clk_nc, rst_n_nc;

  int n_checks;
  int n_fails;

  // Reference counter state
  longint m_stall, m_flush, m_stall_s, m_flush_s;

  hazard_detection #(.REG_ADDR_W(RW), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .pc_redirect(pc_redirect),
    .pc_write_enable(pcw), .if_id_write_enable(ifidw), .flush_ex(flush),
    .stall_count(stall_cnt), .flush_count(flush_cnt)
  );

  hazard_detection #(.REG_ADDR_W(RW), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .pc_redirect(pc_redirect),
    .pc_write_enable(pcw_s), .if_id_write_enable(ifidw_s), .flush_ex(flush_s),
    .stall_count(stall_cnt_s), .flush_count(flush_cnt_s)
  );

  hazard_detection #(.REG_ADDR_W(RW), .CNT_W(32)) u_nc (
    .clk(clk_nc), .rst_n(rst_n_nc), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .pc_redirect(pc_redirect),
    .pc_write_enable(pcw_n), .if_id_write_enable(ifidw_n), .flush_ex(flush_n),
    .stall_count(stall_cnt_n), .flush_count(flush_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat_inc(input longint v, input longint max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  // Applies one cycle of stimulus: drives inputs after the falling edge,
  // checks the combinational decision against the rules, clocks one edge,
  // then checks the counters against the reference.
  task automatic apply(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [RW-1:0] rd, input logic mr, input logic redir,
                       input logic rstn);
    logic e_stall, e_flush;
    @(negedge clk);
    id_rs1      = rs1;
    id_rs2      = rs2;
    ex_rd       = rd;
    ex_memread  = mr;
    pc_redirect = redir;
    rst_n       = rstn;
    e_stall = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    e_flush = !e_stall && redir;
    #1;
    check("pc_write_enable",      32'(pcw),     32'(!e_stall));
    check("if_id_write_enable",   32'(ifidw),   32'(!e_stall));
    check("flush_ex",             32'(flush),   32'(e_flush));
    check("sat_pc_write_enable",  32'(pcw_s),   32'(!e_stall));
    check("sat_flush_ex",         32'(flush_s), 32'(e_flush));
    check("nc_pc_write_enable",   32'(pcw_n),   32'(!e_stall));
    check("nc_if_id_write_enable",32'(ifidw_n), 32'(!e_stall));
    check("nc_flush_ex",          32'(flush_n), 32'(e_flush));
    @(posedge clk);
    if (!rstn) begin
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      if (e_stall) begin
        m_stall   = sat_inc(m_stall, 64'hFFFF_FFFF);
        m_stall_s = sat_inc(m_stall_s, 3);
      end
      if (e_flush) begin
        m_flush   = sat_inc(m_flush, 64'hFFFF_FFFF);
        m_flush_s = sat_inc(m_flush_s, 3);
      end
    end
    #1;
    check("stall_count",     stall_cnt,          32'(m_stall));
    check("flush_count",     flush_cnt,          32'(m_flush));
    check("sat_stall_count", 32'(stall_cnt_s),   32'(m_stall_s));
    check("sat_flush_count", 32'(flush_cnt_s),   32'(m_flush_s));
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    clk_nc = 1'bx; rst_n_nc = 1'bx;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; ex_memread = 1'b0; pc_redirect = 1'b0;
    rst_n = 1'b0;

    // Reset with a load-use present: outputs still track inputs
    apply(5'd2, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    apply(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
    check("reset_stall_zero", stall_cnt, 32'd0);
    check("reset_flush_zero", flush_cnt, 32'd0);

    // Directed cases
    apply(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);   // no hazard
    apply(5'd2, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1);   // rs1 load-use
    apply(5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1);   // rs2 load-use
    apply(5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1);   // both match, single stall
    check("stall_after_three", stall_cnt, 32'd3);
    apply(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);   // x0 exempt
    apply(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);   // x0 exempt, both x0
    apply(5'd2, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1);   // match but not a load
    apply(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1);   // redirect
    check("flush_after_one", flush_cnt, 32'd1);
    apply(5'd2, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);   // stall beats redirect
    check("prio_stall", stall_cnt, 32'd4);
    check("prio_flush", flush_cnt, 32'd1);

    // Mid-operation reset, then saturation of the 2-bit instance
    apply(5'd2, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    check("midrst_stall_zero", stall_cnt, 32'd0);
    for (int i = 0; i < 5; i++) apply(5'd7, 5'd9, 5'd7, 1'b1, 1'b0, 1'b1);
    check("sat_stall_at_3", 32'(stall_cnt_s), 32'd3);
    check("wide_stall_at_5", stall_cnt, 32'd5);
    for (int i = 0; i < 4; i++) apply(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1);
    check("sat_flush_at_3", 32'(flush_cnt_s), 32'd3);

    // Random traffic; small register range to make matches frequent
    for (int i = 0; i < 400; i++) begin
      apply(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
            RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 31) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_hazard_detection

// File: doc/hazard_detection.md
Name: hazard_detection

Overview:
- Pipeline hazard unit for the 5-stage RV32 core; sits beside the ID/EX boundary.
- Detects load-use data hazards (stall PC and IF/ID) and control redirects (flush the instruction entering EX).
- Hazard outputs are purely combinational, so the decision is available in the same cycle as its inputs.
- Also keeps saturating clocked statistics counters for stalls and flushes.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  core clock; clocks only the statistics counters.
- rst_n  in  1  synchronous active-low reset.
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_memread  in  1  instruction in EX is a load.
- pc_redirect  in  1  taken branch or jump resolved this cycle.
- pc_write_enable  out  1  1 = PC may update.
- if_id_write_enable  out  1  1 = IF/ID register may update.
- flush_ex  out  1  1 = convert the instruction entering EX into a bubble.
- stall_count  out  CNT_W  number of cycles with a load-use stall.
- flush_count  out  CNT_W  number of cycles with a flush.

Behaviour:
- load_use = ex_memread AND (ex_rd != 0) AND (ex_rd == id_rs1 OR ex_rd == id_rs2).
- Priority, combinational, no latency:
  - load_use = 1: pc_write_enable = 0, if_id_write_enable = 0, flush_ex = 0, regardless of pc_redirect.
  - else pc_redirect = 1: pc_write_enable = 1, if_id_write_enable = 1, flush_ex = 1.
  - else: pc_write_enable = 1, if_id_write_enable = 1, flush_ex = 0.
- x0 never causes a stall, even if id_rs1 or id_rs2 is also 0.
- ex_memread = 0 never stalls, even when register indices match.
- rs1 and rs2 matching simultaneously gives a single stall (same outputs).
- Combinational outputs do not depend on clk or rst_n. They must be correct with clk and rst_n undriven, and during reset.
- Counters, updated at posedge clk:
  - rst_n = 0: both counters are cleared to 0 on that edge. Reset mid-operation clears them immediately at the next edge; hazard outputs are unaffected.
  - Otherwise stall_count increments when load_use = 1.
  - Otherwise flush_count increments when the flush_ex output = 1, so flush is never counted in a load-use cycle.
  - Both counters saturate at all-ones; there is no wrap-around.
- No X-propagation tricks: compare inputs with ==, and produce a defined output for any known inputs.

Decomposition:
- Shared package core_pkg holds:
  - REG_ADDR_W;
  - REG_X0 = 5'd0.
- One natural sub-module: hazard_sat_counter (parameter CNT_W; inputs clk, rst_n, inc; output count), instantiated twice for the statistics counters.
- The hazard decode logic stays inline in hazard_detection.

Test Plan:
- rs1=1, rs2=2, rd=3, memread=0, redirect=0 -> pcW=1, ifidW=1, flush=0.
- rs1=2, rs2=1, rd=2, memread=1, redirect=0 -> 0,0,0. Then rs1=1, rs2=2, same rd -> 0,0,0. stall_count +1 per clocked cycle.
- rs1=0, rs2=1, rd=0, memread=1 -> 1,1,0 (x0 exempt). rs1=2, rd=2, memread=0 -> 1,1,0.
- rs1=1, rs2=2, rd=3, memread=0, redirect=1 -> 1,1,1. flush_count increments.
- rs1=2, rs2=1, rd=2, memread=1, redirect=1 -> 0,0,0 (stall priority). Only stall_count increments.
- Counters:
  - Hold rst_n=0 for one edge -> both counters read 0, hazard outputs still track inputs.
  - With CNT_W=2, force 5 stall cycles -> stall_count saturates at 3.
  - Leave clk and rst_n undriven -> all combinational checks above still pass.
